// File: rtl/instr_mem_prog.sv
// Loadable instruction memory for the mini-MIPS datapath: registered 1-cycle fetch,
// programming port, post-reset sweep that clears the array to NOP.
module instr_mem_prog #(
    parameter int          ADDR_W = 32,
    parameter int          DEPTH  = 128,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic              prog_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PROG  = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] clr_idx_r;
    logic [31:0]      mem [DEPTH];

    logic             fetch_ok_s;
    logic             prog_ok_s;
    logic [IDX_W-1:0] fetch_idx_s;
    logic [IDX_W-1:0] prog_idx_s;
    logic             fetch_accept_s;

    // A byte address is usable when word-aligned and its word index lies inside the array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-3:0] word;
        word = addr[ADDR_W-1:2];
        return (addr[1:0] == 2'b00) && (word < (ADDR_W-2)'(DEPTH));
    endfunction

    // Address decode; indices are forced to zero when invalid so the array is never over-indexed.
    always_comb begin
        fetch_ok_s = addr_ok(fetch_pc);
        prog_ok_s  = addr_ok(prog_addr);
        if (fetch_ok_s) begin
            fetch_idx_s = fetch_pc[IDX_W+1:2];
        end else begin
            fetch_idx_s = {IDX_W{1'b0}};
        end
        if (prog_ok_s) begin
            prog_idx_s = prog_addr[IDX_W+1:2];
        end else begin
            prog_idx_s = {IDX_W{1'b0}};
        end
    end

    assign fetch_ready    = (state_r == ST_RUN) && !prog_en;
    assign fetch_accept_s = fetch_req && fetch_ready;

    // Array write port: clearing sweep or programming writes; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_idx_r] <= NOP;
        end else if ((state_r == ST_PROG) && prog_we && prog_ok_s) begin
            mem[prog_idx_s] <= prog_data;
        end
    end

    // Control FSM plus registered fetch response and programming error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            clr_idx_r   <= {IDX_W{1'b0}};
            instr       <= NOP;
            instr_pc    <= {ADDR_W{1'b0}};
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            prog_err    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            prog_err    <= 1'b0;
            if (fetch_accept_s) begin
                instr_valid <= 1'b1;
                instr_pc    <= fetch_pc;
                if (fetch_ok_s) begin
                    instr     <= mem[fetch_idx_s];
                    fetch_err <= 1'b0;
                end else begin
                    instr     <= NOP;
                    fetch_err <= 1'b1;
                end
            end
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + IDX_W'(1);
                    if (clr_idx_r == IDX_W'(DEPTH - 1)) begin
                        state_r   <= ST_RUN;
                        clr_idx_r <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (prog_en) begin
                        state_r <= ST_PROG;
                    end
                end
                ST_PROG: begin
                    if (prog_we && !prog_ok_s) begin
                        prog_err <= 1'b1;
                    end
                    if (!prog_en) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench: two instances (DEPTH 128 and 100) share stimulus; an array/queue
// reference model predicts responses and a negedge monitor compares them.
module tb_instr_mem_prog;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_en = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = 32'h0;
    logic [31:0] prog_data = 32'h0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = 32'h0;

    logic [1:0]       prog_err_o, fetch_ready_o, instr_valid_o, fetch_err_o;
    logic [1:0][31:0] instr_o, instr_pc_o;

    instr_mem_prog #(.ADDR_W(32), .DEPTH(128), .NOP(NOP)) dut_a (
        .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err_o[0]),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready_o[0]),
        .instr_valid(instr_valid_o[0]), .instr(instr_o[0]), .instr_pc(instr_pc_o[0]),
        .fetch_err(fetch_err_o[0])
    );

    instr_mem_prog #(.ADDR_W(32), .DEPTH(100), .NOP(NOP)) dut_b (
        .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err_o[1]),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready_o[1]),
        .instr_valid(instr_valid_o[1]), .instr(instr_o[1]), .instr_pc(instr_pc_o[1]),
        .fetch_err(fetch_err_o[1])
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word array per instance, cycles of clearing left, programming flag.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    int          depth_m [2] = '{128, 100};
    logic [31:0] mem_m [2][128];
    int          clear_left [2];
    logic        in_prog [2];
    logic        exp_perr [2];
    exp_t        q_a[$];
    exp_t        q_b[$];

    function automatic logic ok_m(input logic [31:0] a, input int depth);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(depth));
    endfunction

    function automatic exp_t mk_exp(input int i, input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.err   = !ok_m(pc, depth_m[i]);
        e.instr = e.err ? NOP : mem_m[i][pc[8:2]];
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                clear_left[i] <= depth_m[i];
                in_prog[i]    <= 1'b0;
                exp_perr[i]   <= 1'b0;
                for (int j = 0; j < 128; j++) mem_m[i][j] <= NOP;
            end
            q_a.delete();
            q_b.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_perr[i] <= 1'b0;
                if (clear_left[i] > 0) begin
                    clear_left[i] <= clear_left[i] - 1;
                end else if (in_prog[i]) begin
                    if (prog_we) begin
                        if (ok_m(prog_addr, depth_m[i])) mem_m[i][prog_addr[8:2]] <= prog_data;
                        else exp_perr[i] <= 1'b1;
                    end
                    if (!prog_en) in_prog[i] <= 1'b0;
                end else begin
                    if (fetch_req && !prog_en) begin
                        if (i == 0) q_a.push_back(mk_exp(0, fetch_pc));
                        else q_b.push_back(mk_exp(1, fetch_pc));
                    end
                    if (prog_en) in_prog[i] <= 1'b1;
                end
            end
        end
    end

    task automatic mon(input int i);
        exp_t e;
        int   n;
        n = (i == 0) ? q_a.size() : q_b.size();
        if (instr_valid_o[i]) begin
            if (n == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid[%0d]: got instr_valid=1 expected 0", i);
            end else begin
                if (i == 0) e = q_a.pop_front();
                else e = q_b.pop_front();
                chk($sformatf("instr[%0d] pc=%h", i, e.pc), instr_o[i], e.instr);
                chk($sformatf("instr_pc[%0d]", i), instr_pc_o[i], e.pc);
                chk($sformatf("fetch_err[%0d] pc=%h", i, e.pc), 32'(fetch_err_o[i]), 32'(e.err));
            end
        end else if (n != 0) begin
            tests++;
            fails++;
            $display("FAIL missing_valid[%0d]: got instr_valid=0 expected 1", i);
            if (i == 0) void'(q_a.pop_front());
            else void'(q_b.pop_front());
        end
    endtask

    // Monitor: compares every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("fetch_ready[%0d]", i), 32'(fetch_ready_o[i]),
                    32'((clear_left[i] == 0) && !in_prog[i] && !prog_en));
                chk($sformatf("prog_err[%0d]", i), 32'(prog_err_o[i]), 32'(exp_perr[i]));
                mon(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        fetch_req = 1'b0;
    endtask

    task automatic fetch_chk(input logic [31:0] pc, input logic [31:0] exp_instr, input logic exp_err);
        fetch(pc);
        chk($sformatf("direct_valid pc=%h", pc), 32'(instr_valid_o[0]), 32'h1);
        chk($sformatf("direct_instr pc=%h", pc), instr_o[0], exp_instr);
        chk($sformatf("direct_err pc=%h", pc), 32'(fetch_err_o[0]), 32'(exp_err));
    endtask

    task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!fetch_ready_o[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tests++;
            fails++;
            $display("FAIL wait_ready: got timeout expected fetch_ready within 1000 cycles");
        end
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return {$urandom_range(0, 127), 2'b00};
            1: return {$urandom_range(0, 127), 2'b00} | 32'($urandom_range(1, 3));
            2: return {$urandom_range(128, 255), 2'b00};
            default: return {$urandom_range(95, 105), 2'b00};
        endcase
    endfunction

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!fetch_ready_o[0] && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles", 32'(cnt), 32'd128);
        step();
        fetch_chk(32'h40, NOP, 1'b0);

        prog_en = 1'b1;
        step();
        prog_write(32'h4, 32'h0109_8020);
        prog_write(32'h8, 32'h3510_003D);
        prog_write(32'h70, 32'h014C_9820);
        prog_en = 1'b0;
        step();
        fetch_chk(32'h4, 32'h0109_8020, 1'b0);
        chk("pc_0x4", instr_pc_o[0], 32'h4);
        fetch_chk(32'h8, 32'h3510_003D, 1'b0);
        chk("pc_0x8", instr_pc_o[0], 32'h8);
        fetch_chk(32'h70, 32'h014C_9820, 1'b0);
        chk("pc_0x70", instr_pc_o[0], 32'h70);

        fetch_chk(32'h6, NOP, 1'b1);
        fetch_chk(32'h200, NOP, 1'b1);
        fetch_chk(32'h1FC, NOP, 1'b0);
        chk("b_err_0x1fc", 32'(fetch_err_o[1]), 32'h1);
        fetch_chk(32'h18C, NOP, 1'b0);
        chk("b_err_0x18c", 32'(fetch_err_o[1]), 32'h0);
        fetch_chk(32'h190, NOP, 1'b0);
        chk("b_err_0x190", 32'(fetch_err_o[1]), 32'h1);

        prog_en   = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = 32'h4;
        #1 chk("ready_drop", 32'(fetch_ready_o[0]), 32'h0);
        step();
        fetch_req = 1'b0;
        chk("no_valid_on_prog", 32'(instr_valid_o[0]), 32'h0);
        prog_write(32'h7, 32'hDEAD_BEEF);
        chk("prog_err_0x7", 32'(prog_err_o[0]), 32'h1);
        prog_write(32'h1000, 32'hCAFE_F00D);
        chk("prog_err_range", 32'(prog_err_o[0]), 32'h1);
        prog_en = 1'b0;
        step();
        fetch_chk(32'h4, 32'h0109_8020, 1'b0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 6) prog_en = !prog_en;
            prog_we   = 1'($urandom_range(0, 1));
            prog_addr = rand_addr();
            prog_data = $urandom();
            fetch_req = 1'($urandom_range(0, 1));
            fetch_pc  = rand_addr();
            step();
        end
        prog_en   = 1'b0;
        prog_we   = 1'b0;
        fetch_req = 1'b0;
        step();
        prog_en = 1'b1;
        step();
        prog_write(32'h4, 32'h0109_8020);
        prog_en = 1'b0;
        step();

        fetch(32'h4);
        chk("valid_before_reset", 32'(instr_valid_o[0]), 32'h1);
        rst_n = 1'b0;
        #1 chk("valid_async_reset_a", 32'(instr_valid_o[0]), 32'h0);
        chk("valid_async_reset_b", 32'(instr_valid_o[1]), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        wait_ready();
        fetch_chk(32'h4, NOP, 1'b0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
